bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter that sits directly downstream of the round-to-nearest-10 stage. It takes the 32-bit rounded value and converts it to 10 packed BCD digits for the display/print path. It uses an iterative shift-add-3 (double-dabble) algorithm, one bit per clock, with valid/ready handshakes on both sides. It also flags a non-zero least-significant digit, which shows that the upstream value was not rounded.

Parameters:
WIDTH, 32, binary input width.
DIGITS, 10, number of BCD output digits; must be at least ceil(WIDTH*log10(2)), so 10 for 32.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  upstream has a value on in_data.
in_ready  output  1  block can accept a value.
in_data  input  WIDTH  unsigned binary value, normally a multiple of 10.
out_valid  output  1  out_bcd and out_lsd_nonzero are valid.
out_ready  input  1  downstream accepts the result.
out_bcd  output  4*DIGITS  packed BCD; digit k is in bits [4k+3:4k], and digit 0 is the units digit.
out_lsd_nonzero  output  1  units digit of the result is not 0.

Behaviour:
- Reset is asynchronous and active-low.
  - When rst_n goes low: state=IDLE, bit counter=0, shift register=0, out_bcd=0, out_valid=0, out_lsd_nonzero=0.
  - in_ready=1 from the first cycle after reset.
  - Reset during SHIFT or DONE discards the conversion in progress; no partial result is ever presented.
- States: IDLE, SHIFT, DONE.
  - in_ready is 1 only in IDLE.
  - out_valid is 1 only in DONE.
- IDLE:
  - An edge with in_valid=1 captures in_data into the binary shift register.
  - The same edge clears the BCD register, sets counter=0 and moves to SHIFT.
  - With in_valid=0 the block stays in IDLE.
- SHIFT, one iteration per edge:
  - Each digit that is >= 5 gets 3 added (4-bit result, no carry between digits).
  - The {BCD, binary} register is then shifted left by 1, so the binary MSB enters BCD bit 0.
  - The counter increments.
  - On the edge that performs iteration WIDTH (counter == WIDTH-1), the block moves to DONE.
  - On that same edge, out_bcd takes the final BCD value and out_lsd_nonzero = (digit 0 != 0).
- Latency: out_valid rises exactly WIDTH clocks after the accept edge, i.e. 32 cycles.
  - in_data is sampled only on the accept edge; later changes are ignored.
- DONE:
  - out_bcd and out_lsd_nonzero are held stable while out_valid=1 and out_ready=0, for unbounded back-pressure.
  - An edge with out_ready=1 returns the block to IDLE. out_valid drops and in_ready rises in the next cycle.
  - out_bcd keeps its last value after the handshake; it is only meaningful while out_valid=1.
- No overlap: a new input cannot be accepted in the same cycle as the output handshake. Minimum issue interval is WIDTH+2 cycles when out_ready is held high.
- Width and boundary rules:
  - All arithmetic is unsigned.
  - Maximum input 2^32-1 converts to 4294967295 with no overflow in 10 digits.
  - Input 0 gives all-zero BCD.
  - No digit of the result ever exceeds 9.
  - The counter is wide enough for WIDTH, i.e. $clog2(WIDTH)+1 bits.

Decomposition:
- Shared package: WIDTH and DIGITS defaults, a state enumeration {IDLE, SHIFT, DONE}, and a BCD digit typedef (4-bit).
- One natural sub-module, bcd_add3_digit:
  - Combinational, 4-bit in and 4-bit out; output is in+3 when in >= 5, else in unchanged.
  - Instantiated DIGITS times in a generate loop ahead of the shift.

Test Plan:
- in_data=0, out_ready=1 -> out_valid rises 32 cycles after accept; out_bcd=0x0000000000; out_lsd_nonzero=0.
- in_data=1234567890 -> out_bcd=0x1234567890; out_lsd_nonzero=0. Then in_data=4294967290 with no idle gap beyond the handshake -> out_bcd=0x4294967290; in_ready=0 throughout each conversion.
- in_data=4294967295 -> out_bcd=0x4294967295; out_lsd_nonzero=1.
- Back-pressure: in_data=50, out_ready=0 for 20 cycles after out_valid -> out_bcd=0x0000000050 held stable; in_ready=0; in_data changes during the hold are ignored. Release out_ready -> block returns to IDLE next cycle.
- Reset mid-conversion: accept 999999990, assert rst_n=0 at iteration 15 -> out_valid=0 and in_ready=1 after release. A new input 10 then yields 0x0000000010 with no stale digits.
- Input change after accept: present 70, accept it, then drive 80 on in_data during SHIFT -> out_bcd=0x0000000070.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and default sizing for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

    localparam int unsigned WIDTH_DEF  = 32;
    localparam int unsigned DIGITS_DEF = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

endpackage : bin2bcd_seq_pkg

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_add3_digit
    import bin2bcd_seq_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    bcd_digit_t digit_adj;

    // Correction is 4-bit only; no carry leaves the digit.
    always_comb begin
        digit_adj = digit_i;
        if (digit_i >= 4'd5) begin
            digit_adj = digit_i + 4'd3;
        end
    end

    assign digit_o = digit_adj;

endmodule : bcd_add3_digit

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter, one bit per clock, valid/ready on both sides.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_lsd_nonzero
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned BCD_W = 4 * DIGITS;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   out_bcd_q, out_bcd_d;
    logic               lsd_q, lsd_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shift;
    logic [WIDTH-1:0]   bin_shift;

    // Per-digit add-3 correction ahead of the shift.
    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
        bcd_add3_digit u_add3 (
            .digit_i (bcd_q[4*k +: 4]),
            .digit_o (bcd_adj[4*k +: 4])
        );
    end

    // One left shift of {BCD, binary}: binary MSB enters BCD bit 0.
    assign bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};
    assign bin_shift = {bin_q[WIDTH-2:0], 1'b0};

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        out_bcd_d   = out_bcd_q;
        lsd_d       = lsd_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d      = in_data;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    state_d    = SHIFT;
                    in_ready_d = 1'b0;
                end
            end
            SHIFT: begin
                bin_d = bin_shift;
                bcd_d = bcd_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = DONE;
                    out_bcd_d   = bcd_shift;
                    lsd_d       = (bcd_shift[3:0] != 4'd0);
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset discards any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            out_bcd_q   <= '0;
            lsd_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            out_bcd_q   <= out_bcd_d;
            lsd_q       <= lsd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign out_valid       = out_valid_q;
    assign out_bcd         = out_bcd_q;
    assign out_lsd_nonzero = lsd_q;

endmodule : bin2bcd_seq
